trace_capture: RTL and testbench
================================

// Module: trace_capture
// PURPOSE
//   Parametrised on-chip trace recorder for the computer core's observation buses (regA, regB, alu_out).
//   - Runs for a programmable number of clock cycles.
//   - Samples CHANNELS buses of WIDTH bits into a DEPTH-entry FIFO, either every cycle or only on change.
//   - A read port drains the FIFO, replacing fixed-length bench-side printing with a reusable hardware capture.
// PARAMETERS
//   WIDTH     8   bits per observed channel
//   CHANNELS  3   number of channels; ch_data packs channel 0 in bits [WIDTH-1:0]
//   DEPTH     16  FIFO entries; power of two, >=2
//   CNT_W     8   width of cycle_limit and cycle_count
// PORTS
//   clk          in   1                 system clock, rising edge
//   rst          in   1                 asynchronous, active-high reset
//   start        in   1                 pulse: begin capture (honoured in IDLE or DONE only)
//   mode         in   1                 0 = sample every cycle, 1 = sample on change; latched at start
//   cycle_limit  in   CNT_W             cycles to run; latched at start
//   ch_data      in   CHANNELS*WIDTH    packed observed buses
//   rd_en        in   1                 pop request
//   rd_data      out  ENTRY_W           popped entry, registered
//   rd_valid     out  1                 rd_data valid this cycle (1-cycle pulse)
//   empty        out  1                 FIFO empty
//   full         out  1                 FIFO full
//   overflow     out  1                 sticky: a sample was dropped since last start
//   busy         out  1                 state == RUN
//   done         out  1                 state == DONE
//   cycle_count  out  CNT_W             cycles elapsed in the current/last run
//   ENTRY_W = CHANNELS*WIDTH, plus CNT_W when TRACE_TIMESTAMP_EN is defined
// BEHAVIOUR
//   - Reset (async, rst=1) forces:
//       state=IDLE; FIFO pointers/occupancy=0; rd_data=0; rd_valid=0; overflow=0; cycle_count=0;
//       empty=1; full=0; busy=0; done=0.
//   - FSM IDLE -> RUN on start.
//       Same edge: latch mode and limit; flush FIFO; clear overflow and cycle_count; clear last-sample register.
//       start with limit=0 goes directly to DONE; nothing captured.
//   - RUN, each edge:
//       Sample ch_data per mode; cycle_count++.
//       The edge on which cycle_count becomes limit moves to DONE; that edge still samples.
//       Exactly `limit` sample opportunities per run.
//   - RUN ignores start.
//   - DONE holds cycle_count; start restarts exactly as from IDLE (FIFO flushed, unread data discarded).
//   - mode 1 (change):
//       First opportunity of a run always writes.
//       Later opportunities write only if ch_data != last written value.
//   - Write when full and no pop on the same edge: sample dropped; overflow=1 until next start or reset.
//   - Write and pop on the same edge while full: both succeed; occupancy unchanged; no overflow.
//   - Pop:
//       rd_en && !empty -> rd_data = oldest entry, rd_valid=1 on the following cycle.
//       rd_en while empty is ignored: rd_valid=0, rd_data holds.
//   - Pop while empty coinciding with a write: pop ignored; the entry becomes readable next cycle.
//   - Pointers wrap modulo DEPTH.
//   - full and empty are registered from occupancy and reflect the state after the edge.
//   - Reading is permitted in any state, including during RUN.
//   - Reset mid-run aborts the capture and discards all data.
// CONFIGURATION
//   TRACE_TIMESTAMP_EN
//     defined: each entry is {cycle_count_at_sample, ch_data}; timestamp = count before increment (0 for 1st cycle).
//     undefined: entry is ch_data only; no timestamp storage.
// TESTING (CHANNELS=3, WIDTH=8, DEPTH=16, CNT_W=8)
//   1. Reset mid-run -> all outputs at reset values on the same edge; empty=1, busy=0.
//   2. mode=0, limit=5, ch_data steps by 1 from 0x000000:
//        done after 5 edges; 5 pops return 0..4 in order; then empty=1; overflow=0.
//   3. mode=1, limit=10, ch_data held at 0x0A0B0C except cycles 4-5 = 0x0A0B0D:
//        3 entries 0x0A0B0C, 0x0A0B0D, 0x0A0B0C.
//   4. mode=0, limit=20, no reads:
//        16 entries; overflow=1; full=1; pops return samples 0..15.
//      Repeat with rd_en held high: overflow=0, all 20 received.
//   5. limit=0 -> done next cycle; empty=1.
//      start during RUN -> ignored; cycle_count continues uninterrupted.
//   6. TRACE_TIMESTAMP_EN defined, mode=0, limit=3 -> timestamp fields 0, 1, 2.

Source files
------------

// File: rtl/trace_capture.sv
// Trace recorder: samples CHANNELS x WIDTH observation buses into a DEPTH-entry FIFO for a
// programmed number of cycles. Define TRACE_TIMESTAMP_EN to prefix each entry with its cycle count.
module trace_capture #(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned CHANNELS = 3,
    parameter int unsigned DEPTH    = 16,
    parameter int unsigned CNT_W    = 8,
    localparam int unsigned DATA_W  = CHANNELS * WIDTH,
`ifdef TRACE_TIMESTAMP_EN
    localparam int unsigned ENTRY_W = DATA_W + CNT_W
`else
    localparam int unsigned ENTRY_W = DATA_W
`endif
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               mode,
    input  logic [CNT_W-1:0]   cycle_limit,
    input  logic [DATA_W-1:0]  ch_data,
    input  logic               rd_en,
    output logic [ENTRY_W-1:0] rd_data,
    output logic               rd_valid,
    output logic               empty,
    output logic               full,
    output logic               overflow,
    output logic               busy,
    output logic               done,
    output logic [CNT_W-1:0]   cycle_count
);
    localparam int unsigned PTR_W = $clog2(DEPTH);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e              state_q, state_d;
    logic                mode_q, mode_d;
    logic [CNT_W-1:0]    limit_q, limit_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]      occ_q, occ_d;
    logic [ENTRY_W-1:0]  rd_data_q, rd_data_d;
    logic                rd_valid_q, rd_valid_d;
    logic                empty_q, empty_d;
    logic                full_q, full_d;
    logic                ovf_q, ovf_d;
    logic [DATA_W-1:0]   last_q, last_d;
    logic                have_last_q, have_last_d;
    logic [ENTRY_W-1:0]  mem_q [DEPTH];

    logic                flush, sample, do_pop, do_push;
    logic [ENTRY_W-1:0]  wr_entry;

`ifdef TRACE_TIMESTAMP_EN
    assign wr_entry = {count_q, ch_data};
`else
    assign wr_entry = ch_data;
`endif

    always_comb begin
        state_d     = state_q;
        mode_d      = mode_q;
        limit_d     = limit_q;
        count_d     = count_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        occ_d       = occ_q;
        rd_data_d   = rd_data_q;
        ovf_d       = ovf_q;
        last_d      = last_q;
        have_last_d = have_last_q;

        flush   = start && (state_q != StRun);
        sample  = (state_q == StRun) && (!mode_q || !have_last_q || (ch_data != last_q));
        // A pop on the restart edge would read data that is being discarded.
        do_pop  = rd_en && !empty_q && !flush;
        do_push = sample && (!full_q || do_pop);

        rd_valid_d = do_pop;
        if (do_pop) begin
            rd_data_d = mem_q[rd_ptr_q];
        end

        if (flush) begin
            mode_d      = mode;
            limit_d     = cycle_limit;
            count_d     = '0;
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            occ_d       = '0;
            ovf_d       = 1'b0;
            have_last_d = 1'b0;
            state_d     = (cycle_limit == '0) ? StDone : StRun;
        end else begin
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            if (do_push) begin
                wr_ptr_d    = wr_ptr_q + PTR_W'(1);
                last_d      = ch_data;
                have_last_d = 1'b1;
            end
            if (sample && !do_push) begin
                ovf_d = 1'b1;
            end
            if (do_push && !do_pop) begin
                occ_d = occ_q + (PTR_W+1)'(1);
            end else if (do_pop && !do_push) begin
                occ_d = occ_q - (PTR_W+1)'(1);
            end
            if (state_q == StRun) begin
                count_d = count_q + CNT_W'(1);
                if (count_d == limit_q) begin
                    state_d = StDone;
                end
            end
        end

        empty_d = (occ_d == '0);
        full_d  = (occ_d == (PTR_W+1)'(DEPTH));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            mode_q      <= 1'b0;
            limit_q     <= '0;
            count_q     <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            occ_q       <= '0;
            rd_data_q   <= '0;
            rd_valid_q  <= 1'b0;
            empty_q     <= 1'b1;
            full_q      <= 1'b0;
            ovf_q       <= 1'b0;
            last_q      <= '0;
            have_last_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            mode_q      <= mode_d;
            limit_q     <= limit_d;
            count_q     <= count_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            occ_q       <= occ_d;
            rd_data_q   <= rd_data_d;
            rd_valid_q  <= rd_valid_d;
            empty_q     <= empty_d;
            full_q      <= full_d;
            ovf_q       <= ovf_d;
            last_q      <= last_d;
            have_last_q <= have_last_d;
        end
    end

    // Storage needs no reset: occupancy gates every read.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wr_entry;
        end
    end

    assign rd_data     = rd_data_q;
    assign rd_valid    = rd_valid_q;
    assign empty       = empty_q;
    assign full        = full_q;
    assign overflow    = ovf_q;
    assign busy        = (state_q == StRun);
    assign done        = (state_q == StDone);
    assign cycle_count = count_q;
endmodule

// File: tb/tb_trace_capture.sv
// Bench for trace_capture: queue-based reference model checked every cycle, plus directed
// scenarios with literal expectations.
module tb_trace_capture;
    localparam int WIDTH    = 8;
    localparam int CHANNELS = 3;
    localparam int DEPTH    = 16;
    localparam int CNT_W    = 8;
    localparam int DATA_W   = CHANNELS * WIDTH;
`ifdef TRACE_TIMESTAMP_EN
    localparam int ENTRY_W  = DATA_W + CNT_W;
`else
    localparam int ENTRY_W  = DATA_W;
`endif

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               start = 1'b0;
    logic               mode = 1'b0;
    logic [CNT_W-1:0]   cycle_limit = '0;
    logic [DATA_W-1:0]  ch_data = '0;
    logic               rd_en = 1'b0;
    logic [ENTRY_W-1:0] rd_data;
    logic               rd_valid, empty, full, overflow, busy, done;
    logic [CNT_W-1:0]   cycle_count;

    trace_capture #(.WIDTH(WIDTH), .CHANNELS(CHANNELS), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .start(start), .mode(mode), .cycle_limit(cycle_limit),
        .ch_data(ch_data), .rd_en(rd_en), .rd_data(rd_data), .rd_valid(rd_valid),
        .empty(empty), .full(full), .overflow(overflow), .busy(busy), .done(done),
        .cycle_count(cycle_count)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: a queue holding what the trace buffer must contain.
    logic [ENTRY_W-1:0] mq[$];
    logic [ENTRY_W-1:0] m_rd_data = '0;
    logic [DATA_W-1:0]  m_last = '0;
    bit m_rd_valid = 0, m_running = 0, m_finished = 0, m_mode = 0, m_ovf = 0, m_has_last = 0;
    bit m_pop_ok, m_restart, m_want;
    int m_limit = 0, m_count = 0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mq.delete();
            m_rd_data = '0; m_rd_valid = 0; m_running = 0; m_finished = 0;
            m_ovf = 0; m_count = 0; m_has_last = 0;
        end else begin
            m_restart = start && !m_running;
            m_pop_ok  = rd_en && (mq.size() > 0) && !m_restart;
            m_rd_valid = m_pop_ok;
            if (m_pop_ok) m_rd_data = mq.pop_front();
            if (m_restart) begin
                mq.delete();
                m_mode = mode; m_limit = int'(cycle_limit);
                m_ovf = 0; m_count = 0; m_has_last = 0;
                m_running  = (m_limit != 0);
                m_finished = (m_limit == 0);
            end else if (m_running) begin
                m_want = !m_mode || !m_has_last || (ch_data != m_last);
                if (m_want) begin
                    if (mq.size() < DEPTH) begin
`ifdef TRACE_TIMESTAMP_EN
                        mq.push_back({m_count[CNT_W-1:0], ch_data});
`else
                        mq.push_back(ch_data);
`endif
                        m_last = ch_data;
                        m_has_last = 1;
                    end else begin
                        m_ovf = 1;
                    end
                end
                m_count++;
                if (m_count == m_limit) begin
                    m_running = 0;
                    m_finished = 1;
                end
            end
        end
    end

    always @(posedge clk) begin
        #1;
        if (chk_en) begin
            chk("rd_valid", rd_valid, m_rd_valid);
            if (m_rd_valid) chk("rd_data", rd_data, m_rd_data);
            chk("empty", empty, mq.size() == 0);
            chk("full", full, mq.size() == DEPTH);
            chk("overflow", overflow, m_ovf);
            chk("busy", busy, m_running);
            chk("done", done, m_finished);
            chk("cycle_count", cycle_count, m_count[CNT_W-1:0]);
        end
    end

    task automatic start_run(input bit md, input int lim);
        start = 1'b1; mode = md; cycle_limit = CNT_W'(lim);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic pop1(output logic [ENTRY_W-1:0] v);
        rd_en = 1'b1;
        @(negedge clk);
        rd_en = 1'b0;
        chk("pop_valid", rd_valid, 1);
        v = rd_data;
    endtask

    logic [ENTRY_W-1:0] v;
    logic [ENTRY_W-1:0] got[$];
    logic [DATA_W-1:0]  t3_exp [3];

    initial begin
        t3_exp[0] = 24'h0A0B0C; t3_exp[1] = 24'h0A0B0D; t3_exp[2] = 24'h0A0B0C;
        repeat (2) @(negedge clk);
        chk("rst_empty", empty, 1);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_count", cycle_count, 0);
        rst = 1'b0;
        chk_en = 1'b1;
        @(negedge clk);

        // Every-cycle capture of a ramp.
        start_run(0, 5);
        for (int k = 0; k < 5; k++) begin ch_data = DATA_W'(k); @(negedge clk); end
        chk("t2_done", done, 1);
        chk("t2_count", cycle_count, 5);
        for (int k = 0; k < 5; k++) begin pop1(v); chk("t2_pop", v[DATA_W-1:0], k); end
        chk("t2_empty", empty, 1);
        chk("t2_ovf", overflow, 0);

        // Change-only capture.
        start_run(1, 10);
        for (int k = 1; k <= 10; k++) begin
            ch_data = (k == 4 || k == 5) ? 24'h0A0B0D : 24'h0A0B0C;
            @(negedge clk);
        end
        for (int k = 0; k < 3; k++) begin pop1(v); chk("t3_pop", v[DATA_W-1:0], t3_exp[k]); end
        chk("t3_empty", empty, 1);

        // Overflow without reads.
        start_run(0, 20);
        for (int k = 0; k < 20; k++) begin ch_data = DATA_W'(k); @(negedge clk); end
        chk("t4_full", full, 1);
        chk("t4_ovf", overflow, 1);
        for (int k = 0; k < 16; k++) begin pop1(v); chk("t4_pop", v[DATA_W-1:0], k); end
        chk("t4_empty", empty, 1);

        // Same run drained continuously: nothing lost.
        start_run(0, 20);
        rd_en = 1'b1;
        got.delete();
        for (int k = 0; k < 21; k++) begin
            ch_data = DATA_W'(k);
            @(negedge clk);
            if (rd_valid) got.push_back(rd_data);
        end
        rd_en = 1'b0;
        chk("t4b_received", got.size(), 20);
        for (int k = 0; k < got.size(); k++) chk("t4b_data", got[k][DATA_W-1:0], k);
        chk("t4b_ovf", overflow, 0);

        // Zero-length run, then start ignored mid-run.
        start_run(0, 0);
        chk("t5_done", done, 1);
        chk("t5_empty", empty, 1);
        chk("t5_busy", busy, 0);
        start_run(0, 10);
        repeat (3) @(negedge clk);
        start = 1'b1; cycle_limit = 8'd2;
        @(negedge clk);
        start = 1'b0;
        chk("t5_busy_after_start", busy, 1);
        chk("t5_count_cont", cycle_count, 4);
        repeat (6) @(negedge clk);
        chk("t5_done_10", done, 1);
        chk("t5_count_10", cycle_count, 10);

`ifdef TRACE_TIMESTAMP_EN
        start_run(0, 3);
        repeat (3) @(negedge clk);
        for (int k = 0; k < 3; k++) begin pop1(v); chk("t6_ts", v[ENTRY_W-1 -: CNT_W], k); end
`endif

        // Asynchronous reset in the middle of an overflowing run.
        start_run(0, 20);
        for (int k = 0; k < 18; k++) begin ch_data = DATA_W'(k + 1); @(negedge clk); end
        pop1(v);
        chk("t1_pre_ovf", overflow, 1);
        #2 rst = 1'b1;
        #1;
        chk("t1_busy", busy, 0);
        chk("t1_done", done, 0);
        chk("t1_empty", empty, 1);
        chk("t1_full", full, 0);
        chk("t1_ovf", overflow, 0);
        chk("t1_count", cycle_count, 0);
        chk("t1_rd_valid", rd_valid, 0);
        chk("t1_rd_data", rd_data, 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
